hqm_reset_seq_ctrl: RTL and testbench
=====================================

// Module: hqm_reset_seq_ctrl
// PURPOSE
//  Parametrised hardware reset sequencer for N ordered reset domains.
//  - Runs cold boot, warm reset and power-down/retention flows in RTL.
//  - Flow: power-on, isolation settle, fuse pull handshake, staggered domain release.
//  - Warm reset and power-down assert the domains in reverse order.
//  - Sits between the platform power/reset inputs and the per-domain reset_b trees.
// PARAMETERS
//  N_DOM     4     number of reset domains; domain 0 is released first
//  DLY_W     8     width of the step/settle delay counter
//  STEP_DLY  16    cycles between successive domain release/assert steps (1..2^DLY_W-1)
//  ISO_DLY   4     power-good/isolation settle cycles (1..2^DLY_W-1)
//  TO_W      12    fuse timeout counter width (used only with macro)
//  TO_LIMIT  1024  fuse ack timeout in cycles (< 2^TO_W)
// PORTS
//  prim_freerun_clk  in   1      sequencer clock
//  prim_rst_b        in   1      async active-low reset
//  cold_req          in   1      1-cycle pulse: cold boot (valid from OFF or ACTIVE)
//  warm_req          in   1      1-cycle pulse: warm reset (valid from ACTIVE only)
//  pwr_down_req      in   1      1-cycle pulse: retain + power off (valid from ACTIVE only)
//  fuse_bypass       in   1      1 = skip fuse handshake on cold boot
//  fuse_pull_req     out  1      fuse pull request, held until ack
//  fuse_pull_ack     in   1      fuse pull complete
//  dom_rst_b         out  N_DOM  per-domain reset, active-low
//  pwr_on            out  1      domain power enable
//  retain            out  1      retention save enable
//  seq_busy          out  1      1 in every state except OFF and ACTIVE
//  seq_state         out  3      current FSM state encoding (hqm_reset_seq_pkg)
//  timeout_err       out  1      sticky fuse timeout flag
// BEHAVIOUR
//  Reset: state=OFF; dom_rst_b=0; pwr_on=0; retain=0; fuse_pull_req=0; timeout_err=0.
//  Outputs are registered; all transitions take effect the cycle after their condition.
//  States:
//  - OFF: on cold_req -> PWR_UP. warm_req and pwr_down_req are dropped.
//  - PWR_UP: pwr_on=1; wait ISO_DLY cycles; then go to FUSE, or to REL if fuse_bypass=1.
//  - FUSE: fuse_pull_req=1 until fuse_pull_ack is sampled high.
//    - req drops in the next cycle, with the transition to REL.
//    - An ack seen while req=0 is ignored.
//  - REL: release dom_rst_b[0] on entry, then one more domain index every STEP_DLY cycles.
//    - Go to ACTIVE in the cycle dom_rst_b[N_DOM-1] is released.
//  - ACTIVE: dom_rst_b all 1. Any request -> ASSERT, with its flow latched.
//  - ASSERT: clear dom_rst_b[N_DOM-1] on entry, then one lower index every STEP_DLY cycles.
//    - After index 0 is cleared, wait STEP_DLY more cycles, then branch on the latched flow.
//    - warm -> REL (no fuse pull).
//    - cold -> FUSE, or REL if fuse_bypass=1; pwr_on stays 1.
//    - pwr_down -> RET.
//  - RET: retain=1 for ISO_DLY cycles, then pwr_on=0 and retain=0 -> OFF.
//  Request priority, for simultaneous pulses: pwr_down > cold > warm.
//  Requests while busy are latched in a single pending slot.
//  - The slot keeps only the highest-priority request.
//  - On entry to ACTIVE, a pending request starts its flow with no ACTIVE idle cycle.
//  - pending is cleared when its flow starts.
//  Counters:
//  - The delay counter loads the delay value minus 1 and counts down to 0.
//  - The domain index is $clog2(N_DOM) bits wide, saturates at its end value and never wraps.
//  - N_DOM=1: REL and ASSERT are one step each.
//  Async reset mid-flow: outputs return to their reset values at once.
//  - Pending slot and timeout_err are cleared.
// CONFIGURATION
//  HQM_RST_SEQ_FUSE_TIMEOUT_EN defined:
//  - A TO_W counter runs in FUSE.
//  - After TO_LIMIT cycles without ack, timeout_err is set sticky.
//  - fuse_pull_req drops and the FSM goes to REL (fuses default).
//  - timeout_err is cleared only by prim_rst_b.
//  Not defined:
//  - FUSE waits indefinitely; timeout_err is tied 0 and the TO counter is absent.
// STRUCTURE
//  hqm_reset_seq_pkg holds:
//  - hqm_rst_seq_state_t enum: OFF, PWR_UP, FUSE, REL, ACTIVE, ASSERT, RET.
//  - hqm_rst_seq_flow_t enum: NONE, WARM, COLD, PDN.
//  - The priority resolve function.
//  Sub-module hqm_rst_seq_timer: loadable DLY_W down-counter with a done pulse.
//  - Instanced once; shared by PWR_UP, REL, ASSERT and RET.
// TESTING
//  1. N_DOM=4, STEP_DLY=16, ISO_DLY=4, bypass=0; cold_req from OFF.
//     - pwr_on is high 1 cycle later; fuse_pull_req 4 cycles after that.
//     - Ack after 10 cycles -> dom_rst_b steps 0001,0011,0111,1111 at 16-cycle spacing.
//  2. warm_req in ACTIVE.
//     - dom_rst_b steps 0111,0011,0001,0000, 16 cycles apart.
//     - 16 cycles later re-release with no fuse_pull_req.
//  3. pwr_down_req with warm_req in the same cycle -> power-down flow wins.
//     - After full assert, retain=1 for 4 cycles, then pwr_on=0 and state=OFF.
//  4. cold_req pulse during REL of a warm flow -> pending.
//     - On reaching ACTIVE the cold flow starts next cycle, with fuse handshake; warm not repeated.
//  5. Macro on, TO_LIMIT=1024, ack never returns.
//     - timeout_err=1 at cycle 1024 of FUSE; REL starts; flag survives a later warm flow.
//  6. prim_rst_b asserted mid-ASSERT -> all outputs at reset values immediately, state=OFF.

Source files
------------

// File: rtl/hqm_reset_seq_pkg.sv
// hqm_reset_seq_pkg
//   Shared types and helpers for the hqm_reset_seq_ctrl reset sequencer.
//   - hqm_rst_seq_state_t : sequencer FSM states (encoding is visible on seq_state)
//   - hqm_rst_seq_flow_t  : reset flow kinds, encoded in ascending priority
//   - resolve_req         : picks the winning flow among simultaneous request pulses
//   - merge_flow          : keeps the higher-priority of two flows (pending slot update)

package hqm_reset_seq_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    PWR_UP = 3'd1,
    FUSE   = 3'd2,
    REL    = 3'd3,
    ACTIVE = 3'd4,
    ASSERT = 3'd5,
    RET    = 3'd6
  } hqm_rst_seq_state_t;

  // The numeric order is the priority order, so merging two flows is a max().
  typedef enum logic [1:0] {
    NONE = 2'd0,
    WARM = 2'd1,
    COLD = 2'd2,
    PDN  = 2'd3
  } hqm_rst_seq_flow_t;

  function automatic hqm_rst_seq_flow_t resolve_req(input logic pdn,
                                                    input logic cold,
                                                    input logic warm);
    hqm_rst_seq_flow_t f;
    if (pdn)       f = PDN;
    else if (cold) f = COLD;
    else if (warm) f = WARM;
    else           f = NONE;
    return f;
  endfunction

  function automatic hqm_rst_seq_flow_t merge_flow(input hqm_rst_seq_flow_t a,
                                                   input hqm_rst_seq_flow_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hqm_rst_seq_timer.sv
// hqm_rst_seq_timer
//   Loadable down-counter shared by the timed sequencer states.
//   A load of value V makes done pulse V+1 cycles later, so loading (delay-1)
//   gives a state that lasts exactly "delay" cycles. Reloading in the done
//   cycle chains steps back to back.
// Ports
//   clk       in   1      counter clock
//   rst_b     in   1      async active-low reset
//   load      in   1      load load_val and start counting
//   load_val  in   DLY_W  value to count down from
//   done      out  1      high for the one cycle the running count sits at 0

module hqm_rst_seq_timer
  import hqm_reset_seq_pkg::*;
#(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  output logic             done
);

  logic [DLY_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/hqm_reset_seq_ctrl.sv
// hqm_reset_seq_ctrl
//   Hardware reset sequencer for N_DOM ordered reset domains. Runs cold boot
//   (power-up, isolation settle, fuse pull, staggered release), warm reset and
//   power-down/retention flows. Domains are released low index first and
//   asserted high index first.
//   Optional feature macro: HQM_RST_SEQ_FUSE_TIMEOUT_EN
//     defined   -> fuse handshake times out after TO_LIMIT cycles, sets the
//                  sticky timeout_err and continues with default fuses
//     undefined -> FUSE waits for ack forever, timeout_err tied 0
// Ports
//   prim_freerun_clk  in   1      sequencer clock
//   prim_rst_b        in   1      async active-low reset
//   cold_req          in   1      cold boot pulse (OFF or ACTIVE)
//   warm_req          in   1      warm reset pulse (ACTIVE)
//   pwr_down_req      in   1      retain + power-off pulse (ACTIVE)
//   fuse_bypass       in   1      skip fuse handshake on cold boot
//   fuse_pull_req     out  1      fuse pull request, held until ack
//   fuse_pull_ack     in   1      fuse pull complete
//   dom_rst_b         out  N_DOM  per-domain active-low reset
//   pwr_on            out  1      domain power enable
//   retain            out  1      retention save enable
//   seq_busy          out  1      1 outside OFF and ACTIVE
//   seq_state         out  3      current hqm_rst_seq_state_t
//   timeout_err       out  1      sticky fuse timeout flag

module hqm_reset_seq_ctrl
  import hqm_reset_seq_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int DLY_W    = 8,
  parameter int STEP_DLY = 16,
  parameter int ISO_DLY  = 4,
  parameter int TO_W     = 12,
  parameter int TO_LIMIT = 1024
) (
  input  logic             prim_freerun_clk,
  input  logic             prim_rst_b,
  input  logic             cold_req,
  input  logic             warm_req,
  input  logic             pwr_down_req,
  input  logic             fuse_bypass,
  output logic             fuse_pull_req,
  input  logic             fuse_pull_ack,
  output logic [N_DOM-1:0] dom_rst_b,
  output logic             pwr_on,
  output logic             retain,
  output logic             seq_busy,
  output logic [2:0]       seq_state,
  output logic             timeout_err
);

  // A single-domain build still needs a 1-bit index vector.
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);
  localparam logic [DLY_W-1:0] STEP_LD  = DLY_W'(STEP_DLY - 1);
  localparam logic [DLY_W-1:0] ISO_LD   = DLY_W'(ISO_DLY - 1);

  hqm_rst_seq_state_t state_q, state_d;
  hqm_rst_seq_flow_t  flow_q, flow_d;
  hqm_rst_seq_flow_t  pend_q, pend_d;
  hqm_rst_seq_flow_t  req_now, req_any;
  logic [N_DOM-1:0]   dom_q, dom_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_up, idx_dn;
  logic               pwr_on_q, pwr_on_d;
  logic               retain_q, retain_d;
  logic               fuse_req_q, fuse_req_d;
  logic               tmr_load, tmr_done;
  logic [DLY_W-1:0]   tmr_val;
  logic               go_rel, go_fuse;
  logic               to_expired;

  assign idx_up = idx_q + 1'b1;
  assign idx_dn = idx_q - 1'b1;

  hqm_rst_seq_timer #(
    .DLY_W(DLY_W)
  ) u_timer (
    .clk      (prim_freerun_clk),
    .rst_b    (prim_rst_b),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge prim_freerun_clk or negedge prim_rst_b) begin
    if (!prim_rst_b) begin
      state_q    <= OFF;
      flow_q     <= NONE;
      pend_q     <= NONE;
      dom_q      <= '0;
      idx_q      <= '0;
      pwr_on_q   <= 1'b0;
      retain_q   <= 1'b0;
      fuse_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flow_q     <= flow_d;
      pend_q     <= pend_d;
      dom_q      <= dom_d;
      idx_q      <= idx_d;
      pwr_on_q   <= pwr_on_d;
      retain_q   <= retain_d;
      fuse_req_q <= fuse_req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flow_d     = flow_q;
    pend_d     = pend_q;
    dom_d      = dom_q;
    idx_d      = idx_q;
    pwr_on_d   = pwr_on_q;
    retain_d   = retain_q;
    fuse_req_d = fuse_req_q;
    tmr_load   = 1'b0;
    tmr_val    = STEP_LD;
    go_rel     = 1'b0;
    go_fuse    = 1'b0;
    req_now    = resolve_req(pwr_down_req, cold_req, warm_req);
    req_any    = merge_flow(pend_q, req_now);

    // While busy, requests collapse into the single pending slot.
    if (state_q != OFF && state_q != ACTIVE) begin
      pend_d = merge_flow(pend_q, req_now);
    end

    unique case (state_q)
      OFF: begin
        if (cold_req) begin
          state_d  = PWR_UP;
          pwr_on_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = ISO_LD;
        end
      end
      PWR_UP: begin
        if (tmr_done) begin
          if (fuse_bypass) go_rel  = 1'b1;
          else             go_fuse = 1'b1;
        end
      end
      FUSE: begin
        if (fuse_req_q && fuse_pull_ack) begin
          fuse_req_d = 1'b0;
          go_rel     = 1'b1;
        end else if (to_expired) begin
          fuse_req_d = 1'b0;
          go_rel     = 1'b1;
        end
      end
      REL: begin
        // Only reachable with N_DOM=1: the entry release was already the last one.
        if (idx_q == IDX_LAST) begin
          state_d = ACTIVE;
        end else if (tmr_done) begin
          idx_d         = idx_up;
          dom_d[idx_up] = 1'b1;
          if (idx_up == IDX_LAST) state_d  = ACTIVE;
          else                    tmr_load = 1'b1;
        end
      end
      ACTIVE: begin
        // A pending request is acted on in the very first ACTIVE cycle.
        if (req_any != NONE) begin
          state_d         = ASSERT;
          flow_d          = req_any;
          pend_d          = NONE;
          idx_d           = IDX_LAST;
          dom_d[IDX_LAST] = 1'b0;
          tmr_load        = 1'b1;
        end
      end
      ASSERT: begin
        if (tmr_done) begin
          // Index 0 done means the trailing settle step has elapsed.
          if (idx_q == '0) begin
            case (flow_q)
              PDN: begin
                state_d  = RET;
                retain_d = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = ISO_LD;
              end
              COLD: begin
                if (fuse_bypass) go_rel  = 1'b1;
                else             go_fuse = 1'b1;
              end
              default: go_rel = 1'b1;
            endcase
          end else begin
            idx_d         = idx_dn;
            dom_d[idx_dn] = 1'b0;
            tmr_load      = 1'b1;
          end
        end
      end
      RET: begin
        // Requests left pending across a power-off are discarded, like requests seen in OFF.
        if (tmr_done) begin
          state_d  = OFF;
          pwr_on_d = 1'b0;
          retain_d = 1'b0;
          pend_d   = NONE;
        end
      end
      default: state_d = OFF;
    endcase

    if (go_fuse) begin
      state_d    = FUSE;
      fuse_req_d = 1'b1;
    end
    if (go_rel) begin
      state_d  = REL;
      idx_d    = '0;
      dom_d[0] = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = STEP_LD;
    end
  end

`ifdef HQM_RST_SEQ_FUSE_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            terr_q;

  // An ack in the expiry cycle wins over the timeout.
  assign to_expired = (state_q == FUSE) && !fuse_pull_ack && (to_cnt_q == TO_LAST);

  always_ff @(posedge prim_freerun_clk or negedge prim_rst_b) begin
    if (!prim_rst_b) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == FUSE) ? to_cnt_q + 1'b1 : '0;
      if (to_expired) terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  assign to_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign fuse_pull_req = fuse_req_q;
  assign dom_rst_b     = dom_q;
  assign pwr_on        = pwr_on_q;
  assign retain        = retain_q;
  assign seq_state     = state_q;
  assign seq_busy      = (state_q != OFF) && (state_q != ACTIVE);

endmodule

// File: tb/tb_hqm_reset_seq_ctrl.sv
// tb_hqm_reset_seq_ctrl
//   Directed bench for hqm_reset_seq_ctrl with N_DOM=4, STEP_DLY=16, ISO_DLY=4.
//   Expected values are hand-derived cycle counts from the request pulse.
//   Follows HQM_RST_SEQ_FUSE_TIMEOUT_EN the same way the design does.

module tb_hqm_reset_seq_ctrl;
  import hqm_reset_seq_pkg::*;

  localparam int STEP = 16;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       cold_req = 1'b0;
  logic       warm_req = 1'b0;
  logic       pwr_down_req = 1'b0;
  logic       fuse_bypass = 1'b0;
  logic       fuse_pull_ack = 1'b0;
  logic       fuse_pull_req;
  logic [3:0] dom_rst_b;
  logic       pwr_on;
  logic       retain;
  logic       seq_busy;
  logic [2:0] seq_state;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hqm_reset_seq_ctrl #(
    .N_DOM    (4),
    .DLY_W    (8),
    .STEP_DLY (16),
    .ISO_DLY  (4),
    .TO_W     (12),
    .TO_LIMIT (1024)
  ) dut (
    .prim_freerun_clk (clk),
    .prim_rst_b       (rst_b),
    .cold_req         (cold_req),
    .warm_req         (warm_req),
    .pwr_down_req     (pwr_down_req),
    .fuse_bypass      (fuse_bypass),
    .fuse_pull_req    (fuse_pull_req),
    .fuse_pull_ack    (fuse_pull_ack),
    .dom_rst_b        (dom_rst_b),
    .pwr_on           (pwr_on),
    .retain           (retain),
    .seq_busy         (seq_busy),
    .seq_state        (seq_state),
    .timeout_err      (timeout_err)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #2;
    checks++;
    if ({seq_state, dom_rst_b, pwr_on, retain, fuse_pull_req, timeout_err, seq_busy} !== 12'b000_0000_00000) begin
      failures++;
      $display("[TB] FAIL reset_values state=%0d dom=%b pwr_on=%b retain=%b req=%b terr=%b busy=%b exp all 0",
               seq_state, dom_rst_b, pwr_on, retain, fuse_pull_req, timeout_err, seq_busy);
    end
    tick(2);
    rst_b = 1'b1;
    tick(2);
    checks++;
    if (seq_state !== OFF || pwr_on !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release state=%0d pwr_on=%b exp state=%0d pwr_on=0", seq_state, pwr_on, OFF);
    end
  endtask

  task automatic test_off_drop();
    warm_req = 1'b1;
    tick(1);
    warm_req = 1'b0;
    pwr_down_req = 1'b1;
    tick(1);
    pwr_down_req = 1'b0;
    tick(3);
    checks++;
    if (seq_state !== OFF || pwr_on !== 1'b0 || seq_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL off_drop state=%0d pwr_on=%b busy=%b exp state=%0d pwr_on=0 busy=0",
               seq_state, pwr_on, seq_busy, OFF);
    end
  endtask

  task automatic test_cold_boot();
    logic [3:0] exp_dom;
    fuse_bypass = 1'b0;
    cold_req = 1'b1;
    tick(1);
    cold_req = 1'b0;
    checks++;
    if (pwr_on !== 1'b1 || seq_state !== PWR_UP || seq_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cold_pwr_on pwr_on=%b state=%0d busy=%b exp 1/%0d/1", pwr_on, seq_state, seq_busy, PWR_UP);
    end
    tick(3);
    checks++;
    if (fuse_pull_req !== 1'b0 || seq_state !== PWR_UP) begin
      failures++;
      $display("[TB] FAIL cold_iso_hold req=%b state=%0d exp 0/%0d", fuse_pull_req, seq_state, PWR_UP);
    end
    tick(1);
    checks++;
    if (fuse_pull_req !== 1'b1 || seq_state !== FUSE) begin
      failures++;
      $display("[TB] FAIL cold_fuse_req req=%b state=%0d exp 1/%0d", fuse_pull_req, seq_state, FUSE);
    end
    tick(10);
    checks++;
    if (fuse_pull_req !== 1'b1 || dom_rst_b !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL cold_fuse_wait req=%b dom=%b exp 1/0000", fuse_pull_req, dom_rst_b);
    end
    fuse_pull_ack = 1'b1;
    tick(1);
    fuse_pull_ack = 1'b0;
    exp_dom = 4'b0001;
    checks++;
    if (fuse_pull_req !== 1'b0 || seq_state !== REL || dom_rst_b !== exp_dom) begin
      failures++;
      $display("[TB] FAIL cold_rel_entry req=%b state=%0d dom=%b exp 0/%0d/%b",
               fuse_pull_req, seq_state, dom_rst_b, REL, exp_dom);
    end
    for (int s = 1; s < 4; s++) begin
      tick(STEP - 1);
      checks++;
      if (dom_rst_b !== exp_dom) begin
        failures++;
        $display("[TB] FAIL cold_rel_hold%0d dom=%b exp %b", s, dom_rst_b, exp_dom);
      end
      tick(1);
      exp_dom = {exp_dom[2:0], 1'b1};
      checks++;
      if (dom_rst_b !== exp_dom) begin
        failures++;
        $display("[TB] FAIL cold_rel_step%0d dom=%b exp %b", s, dom_rst_b, exp_dom);
      end
    end
    checks++;
    if (seq_state !== ACTIVE || seq_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cold_active state=%0d busy=%b exp %0d/0", seq_state, seq_busy, ACTIVE);
    end
    fuse_pull_ack = 1'b1;
    tick(1);
    fuse_pull_ack = 1'b0;
    tick(1);
    checks++;
    if (seq_state !== ACTIVE || fuse_pull_req !== 1'b0 || dom_rst_b !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL stray_ack state=%0d req=%b dom=%b exp %0d/0/1111", seq_state, fuse_pull_req, dom_rst_b, ACTIVE);
    end
  endtask

  task automatic test_warm();
    logic [3:0] exp_dom;
    logic       saw_req;
    warm_req = 1'b1;
    tick(1);
    warm_req = 1'b0;
    exp_dom = 4'b0111;
    checks++;
    if (seq_state !== ASSERT || dom_rst_b !== exp_dom) begin
      failures++;
      $display("[TB] FAIL warm_assert_entry state=%0d dom=%b exp %0d/%b", seq_state, dom_rst_b, ASSERT, exp_dom);
    end
    for (int s = 1; s < 4; s++) begin
      tick(STEP - 1);
      checks++;
      if (dom_rst_b !== exp_dom) begin
        failures++;
        $display("[TB] FAIL warm_assert_hold%0d dom=%b exp %b", s, dom_rst_b, exp_dom);
      end
      tick(1);
      exp_dom = exp_dom >> 1;
      checks++;
      if (dom_rst_b !== exp_dom) begin
        failures++;
        $display("[TB] FAIL warm_assert_step%0d dom=%b exp %b", s, dom_rst_b, exp_dom);
      end
    end
    tick(STEP - 1);
    checks++;
    if (seq_state !== ASSERT || dom_rst_b !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL warm_settle state=%0d dom=%b exp %0d/0000", seq_state, dom_rst_b, ASSERT);
    end
    tick(1);
    checks++;
    if (seq_state !== REL || dom_rst_b !== 4'b0001 || fuse_pull_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL warm_rerelease state=%0d dom=%b req=%b exp %0d/0001/0", seq_state, dom_rst_b, fuse_pull_req, REL);
    end
    saw_req = 1'b0;
    for (int c = 0; c < 3 * STEP; c++) begin
      tick(1);
      saw_req = saw_req | fuse_pull_req;
    end
    checks++;
    if (seq_state !== ACTIVE || dom_rst_b !== 4'b1111 || saw_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL warm_active state=%0d dom=%b fuse_req_seen=%b exp %0d/1111/0", seq_state, dom_rst_b, saw_req, ACTIVE);
    end
  endtask

  task automatic test_pwr_down();
    pwr_down_req = 1'b1;
    warm_req = 1'b1;
    tick(1);
    pwr_down_req = 1'b0;
    warm_req = 1'b0;
    checks++;
    if (seq_state !== ASSERT || dom_rst_b !== 4'b0111) begin
      failures++;
      $display("[TB] FAIL pdn_entry state=%0d dom=%b exp %0d/0111", seq_state, dom_rst_b, ASSERT);
    end
    tick(4 * STEP - 1);
    checks++;
    if (seq_state !== ASSERT || dom_rst_b !== 4'b0000 || retain !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pdn_settle state=%0d dom=%b retain=%b exp %0d/0000/0", seq_state, dom_rst_b, retain, ASSERT);
    end
    tick(1);
    checks++;
    if (seq_state !== RET || retain !== 1'b1 || pwr_on !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pdn_ret_entry state=%0d retain=%b pwr_on=%b exp %0d/1/1", seq_state, retain, pwr_on, RET);
    end
    tick(3);
    checks++;
    if (seq_state !== RET || retain !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pdn_ret_hold state=%0d retain=%b exp %0d/1", seq_state, retain, RET);
    end
    tick(1);
    checks++;
    if (seq_state !== OFF || retain !== 1'b0 || pwr_on !== 1'b0 || seq_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pdn_off state=%0d retain=%b pwr_on=%b busy=%b exp %0d/0/0/0", seq_state, retain, pwr_on, seq_busy, OFF);
    end
    tick(3);
    checks++;
    if (seq_state !== OFF || dom_rst_b !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL pdn_stay_off state=%0d dom=%b exp %0d/0000", seq_state, dom_rst_b, OFF);
    end
  endtask

  task automatic test_pending();
    fuse_bypass = 1'b1;
    cold_req = 1'b1;
    tick(1);
    cold_req = 1'b0;
    tick(4);
    checks++;
    if (seq_state !== REL || dom_rst_b !== 4'b0001 || fuse_pull_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bypass_rel state=%0d dom=%b req=%b exp %0d/0001/0", seq_state, dom_rst_b, fuse_pull_req, REL);
    end
    tick(3 * STEP);
    warm_req = 1'b1;
    tick(1);
    warm_req = 1'b0;
    tick(4 * STEP);
    checks++;
    if (seq_state !== REL || dom_rst_b !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL pend_warm_rel state=%0d dom=%b exp %0d/0001", seq_state, dom_rst_b, REL);
    end
    fuse_bypass = 1'b0;
    tick(4);
    cold_req = 1'b1;
    tick(1);
    cold_req = 1'b0;
    tick(3 * STEP - 5);
    checks++;
    if (seq_state !== ACTIVE || dom_rst_b !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL pend_active state=%0d dom=%b exp %0d/1111", seq_state, dom_rst_b, ACTIVE);
    end
    tick(1);
    checks++;
    if (seq_state !== ASSERT || dom_rst_b !== 4'b0111) begin
      failures++;
      $display("[TB] FAIL pend_start state=%0d dom=%b exp %0d/0111", seq_state, dom_rst_b, ASSERT);
    end
    tick(4 * STEP);
    checks++;
    if (seq_state !== FUSE || fuse_pull_req !== 1'b1 || pwr_on !== 1'b1 || dom_rst_b !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL pend_cold_fuse state=%0d req=%b pwr_on=%b dom=%b exp %0d/1/1/0000",
               seq_state, fuse_pull_req, pwr_on, dom_rst_b, FUSE);
    end
    fuse_pull_ack = 1'b1;
    tick(1);
    fuse_pull_ack = 1'b0;
    tick(3 * STEP + 3);
    checks++;
    if (seq_state !== ACTIVE || seq_busy !== 1'b0 || dom_rst_b !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL pend_no_repeat state=%0d busy=%b dom=%b exp %0d/0/1111", seq_state, seq_busy, dom_rst_b, ACTIVE);
    end
  endtask

  task automatic test_timeout();
    logic exp_terr;
    fuse_bypass = 1'b0;
    cold_req = 1'b1;
    tick(1);
    cold_req = 1'b0;
    tick(4 * STEP);
    checks++;
    if (seq_state !== FUSE || fuse_pull_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL to_fuse_entry state=%0d req=%b exp %0d/1", seq_state, fuse_pull_req, FUSE);
    end
`ifdef HQM_RST_SEQ_FUSE_TIMEOUT_EN
    exp_terr = 1'b1;
    tick(1023);
    checks++;
    if (seq_state !== FUSE || timeout_err !== 1'b0 || fuse_pull_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL to_before state=%0d terr=%b req=%b exp %0d/0/1", seq_state, timeout_err, fuse_pull_req, FUSE);
    end
    tick(1);
    checks++;
    if (seq_state !== REL || timeout_err !== 1'b1 || fuse_pull_req !== 1'b0 || dom_rst_b !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL to_expire state=%0d terr=%b req=%b dom=%b exp %0d/1/0/0001",
               seq_state, timeout_err, fuse_pull_req, dom_rst_b, REL);
    end
`else
    exp_terr = 1'b0;
    tick(1100);
    checks++;
    if (seq_state !== FUSE || timeout_err !== 1'b0 || fuse_pull_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fuse_wait_forever state=%0d terr=%b req=%b exp %0d/0/1", seq_state, timeout_err, fuse_pull_req, FUSE);
    end
    fuse_pull_ack = 1'b1;
    tick(1);
    fuse_pull_ack = 1'b0;
    checks++;
    if (seq_state !== REL || timeout_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fuse_late_ack state=%0d terr=%b exp %0d/0", seq_state, timeout_err, REL);
    end
`endif
    tick(3 * STEP);
    warm_req = 1'b1;
    tick(1);
    warm_req = 1'b0;
    tick(7 * STEP);
    checks++;
    if (seq_state !== ACTIVE || timeout_err !== exp_terr) begin
      failures++;
      $display("[TB] FAIL to_sticky state=%0d terr=%b exp %0d/%b", seq_state, timeout_err, ACTIVE, exp_terr);
    end
  endtask

  task automatic test_reset_mid_flow();
    warm_req = 1'b1;
    tick(1);
    warm_req = 1'b0;
    tick(20);
    cold_req = 1'b1;
    tick(1);
    cold_req = 1'b0;
    tick(2);
    #3 rst_b = 1'b0;
    #1;
    checks++;
    if ({seq_state, dom_rst_b, pwr_on, retain, fuse_pull_req, timeout_err, seq_busy} !== 12'b000_0000_00000) begin
      failures++;
      $display("[TB] FAIL reset_mid state=%0d dom=%b pwr_on=%b retain=%b req=%b terr=%b busy=%b exp all 0",
               seq_state, dom_rst_b, pwr_on, retain, fuse_pull_req, timeout_err, seq_busy);
    end
    tick(2);
    rst_b = 1'b1;
    tick(2);
    fuse_bypass = 1'b1;
    cold_req = 1'b1;
    tick(1);
    cold_req = 1'b0;
    tick(4 + 3 * STEP + 2);
    checks++;
    if (seq_state !== ACTIVE || dom_rst_b !== 4'b1111) begin
      failures++;
      $display("[TB] FAIL reset_clears_pending state=%0d dom=%b exp %0d/1111", seq_state, dom_rst_b, ACTIVE);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_off_drop();
    test_cold_boot();
    test_warm();
    test_pwr_down();
    test_pending();
    test_timeout();
    test_reset_mid_flow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
